// File: rtl/tinyalu_pkg.sv
// Shared types for the ALU593 command sequencer: opcodes, command/response records and FSM states.
package tinyalu_pkg;

  typedef enum logic [3:0] {
    op_nop  = 4'h0,
    op_add  = 4'h1,
    op_and  = 4'h2,
    op_xor  = 4'h3,
    op_mul  = 4'h4,
    op_sp0  = 4'h5,
    op_nop1 = 4'h6,
    op_res1 = 4'h7,
    op_res2 = 4'h8,
    op_res3 = 4'h9
  } alu_opcode_t;

  typedef struct packed {
    alu_opcode_t op;
    logic [7:0]  a;
    logic [7:0]  b;
  } alu_cmd_t;

  typedef struct packed {
    alu_opcode_t op;
    logic [15:0] result;
    logic        error;
    logic        timeout;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_ISSUE_NOP = 2'd1,
    SEQ_WAIT_DONE = 2'd2,
    SEQ_RESP      = 2'd3
  } seq_state_t;

  // Both nop encodings get a single start pulse and never produce a response.
  function automatic logic is_nop_op(alu_opcode_t op);
    return (op == op_nop) || (op == op_nop1);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with full/empty flags; DEPTH must be a power of two, >= 2.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the ALU593 start/done interface: buffers {op,a,b} commands, issues them one at a time,
// and returns {op,result,error,timeout} over a valid/ready response port.
module alu_cmd_sequencer
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [15:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] IDLE      = SEQ_IDLE;
  localparam logic [1:0] ISSUE_NOP = SEQ_ISSUE_NOP;
  localparam logic [1:0] WAIT_DONE = SEQ_WAIT_DONE;
  localparam logic [1:0] RESP      = SEQ_RESP;

  logic [1:0]       state;
  logic [CNT_W-1:0] tmo_cnt;
  alu_cmd_t         cmd_in;
  alu_cmd_t         head;
  alu_cmd_t         issue_r;
  alu_rsp_t         rsp_r;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign cmd_in    = {cmd_op, cmd_a, cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(alu_cmd_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (cmd_in),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // One command in flight at a time; alu_start and operands stay registered for the whole transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      issue_r   <= '0;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            issue_r   <= head;
            alu_start <= 1'b1;
            if (is_nop_op(head.op)) begin
              state <= ISSUE_NOP;
            end else begin
              state   <= WAIT_DONE;
              tmo_cnt <= '0;
            end
          end
        end
        ISSUE_NOP: begin
          alu_start <= 1'b0;
          state     <= IDLE;
        end
        WAIT_DONE: begin
          // done is checked first so it wins over an expiring counter in the same cycle
          if (alu_done) begin
            alu_start <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_r     <= '{op: issue_r.op, result: alu_result, error: alu_error, timeout: 1'b0};
            state     <= RESP;
          end else if (tmo_cnt == CNT_LAST) begin
            alu_start <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_r     <= '{op: issue_r.op, result: 16'h0000, error: 1'b0, timeout: 1'b1};
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          alu_start <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op      = issue_r.op;
  assign alu_a       = issue_r.a;
  assign alu_b       = issue_r.b;
  assign rsp_op      = rsp_r.op;
  assign rsp_result  = rsp_r.result;
  assign rsp_error   = rsp_r.error;
  assign rsp_timeout = rsp_r.timeout;
  assign busy        = !fifo_empty || (state != IDLE);

endmodule
